pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the generalised successor to the fixed-field inter-stage registers between EX and MEM and between other stages. It carries an opaque DATA_W-bit payload, so the ex_wd/ex_wreg/ex_wdata/memop/maddr/reg2 fields are concatenated by the instantiating stage. Per-stage stall vectors are replaced by backpressure, and a flush drains the stage to bubbles. A saturating bubble counter supports pipeline performance analysis.

---
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Carries an opaque payload and counts downstream bubble cycles (saturating).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_EMPTY | nothing held, out_data shows BUBBLE_VAL
// S_ONE   | one entry in main register, skid unused
// S_FULL  | main holds the head, skid holds the next entry; in_ready low
module pipe_skid_reg #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic [CNT_W-1:0]    r_bubble_cnt;

  logic                w_accept;
  logic                w_fire;
  logic                w_bubble;

  // Handshake flags come only from the state register, so in_ready never sees out_ready.
  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_accept   = in_valid & in_ready;
  assign w_fire     = out_valid & out_ready;
  assign w_bubble   = out_ready & ~out_valid;

  assign out_data   = r_main;
  assign occupancy  = r_state;
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else if (flush) begin
      // An accept on this cycle still completes upstream; its payload is simply dropped.
      r_state <= S_EMPTY;
      r_main  <= BUBBLE_VAL;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state <= S_ONE;
            r_main  <= in_data;
          end
        end
        S_ONE: begin
          if (w_accept && w_fire) begin
            r_main <= in_data;
          end else if (w_accept) begin
            r_state <= S_FULL;
            r_skid  <= in_data;
          end else if (w_fire) begin
            r_state <= S_EMPTY;
            r_main  <= BUBBLE_VAL;
          end
        end
        S_FULL: begin
          if (w_fire) begin
            r_state <= S_ONE;
            r_main  <= r_skid;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_main  <= BUBBLE_VAL;
        end
      endcase
    end
  end

  // Flush deliberately leaves the counter alone; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a random valid/ready soak.
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic       cnt_clr = 1'b0;
  logic [1:0] bubble_cnt;

  int n_pass  = 0;
  int n_total = 0;

  pipe_skid_reg #(.DATA_W(8), .BUBBLE_VAL(8'h00), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .cnt_clr    (cnt_clr),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of at most two entries plus a saturating counter.
  logic [7:0] mq[$];
  int         mcnt = 0;
  bit         m_acc = 0;
  int         n_acc = 0;

  always @(posedge clk) begin
    int  sz;
    bit  acc, fire;
    sz   = mq.size();
    acc  = in_valid && (sz < 2);
    fire = (sz > 0) && out_ready;
    if (rst) begin
      mq.delete();
      mcnt  = 0;
      m_acc = 0;
    end else begin
      m_acc = acc;
      if (acc) n_acc++;
      if (cnt_clr) mcnt = 0;
      else if (out_ready && (sz == 0) && (mcnt < 3)) mcnt++;
      if (flush) mq.delete();
      else begin
        if (fire) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of the DUT against the model, plus in-order scoreboard.
  bit         chk_on = 0;
  bit         sb_on = 0;
  logic [7:0] sb_exp = 8'h00;
  int         n_deliv = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
      chk("model_out_data", {24'b0, out_data}, {24'b0, (mq.size() > 0) ? mq[0] : 8'h00});
      chk("model_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
      chk("model_occupancy", {30'b0, occupancy}, mq.size());
      chk("model_bubble_cnt", {30'b0, bubble_cnt}, mcnt);
      if (sb_on && out_valid && out_ready && !rst && !flush) begin
        chk("sb_order", {24'b0, out_data}, {24'b0, sb_exp});
        sb_exp = sb_exp + 8'h01;
        n_deliv++;
      end
    end
  end

  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input logic ov, input logic [7:0] od,
                     input logic ir, input logic [1:0] occ);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, "_out_data"}, {24'b0, out_data}, {24'b0, od});
    chk({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, ir});
    chk({tag, "_occupancy"}, {30'b0, occupancy}, {30'b0, occ});
  endtask

  initial begin
    logic [7:0] nxt;
    // Reset
    rst = 1'b1;
    step(1, 8'h55, 1, 0, 0);
    chk_on = 1;
    lit("reset", 0, 8'h00, 1, 0);
    chk("reset_bubble_cnt", {30'b0, bubble_cnt}, 32'd0);
    rst = 1'b0;

    // Streaming at full rate
    for (int i = 1; i <= 5; i++) begin
      step(1, 8'(i), 1, 0, 0);
      lit("stream", 1, 8'(i), 1, 1);
    end
    step(0, 8'h00, 1, 0, 0);
    lit("stream_drain", 0, 8'h00, 1, 0);

    // Backpressure into the skid register
    step(1, 8'hA1, 0, 0, 0);
    lit("bp_a1", 1, 8'hA1, 1, 1);
    step(1, 8'hA2, 0, 0, 0);
    lit("bp_a2", 1, 8'hA1, 0, 2);
    step(1, 8'hA3, 0, 0, 0);
    lit("bp_hold", 1, 8'hA1, 0, 2);
    step(1, 8'hA3, 1, 0, 0);
    lit("bp_rel1", 1, 8'hA2, 1, 1);
    step(1, 8'hA3, 1, 0, 0);
    lit("bp_rel2", 1, 8'hA3, 1, 1);
    step(0, 8'h00, 1, 0, 0);
    lit("bp_rel3", 0, 8'h00, 1, 0);

    // Flush while full
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(1, 8'hA3, 0, 1, 0);
    lit("flush", 0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    lit("flush_after", 0, 8'h00, 1, 0);

    // Bubble counter saturation and clear
    step(0, 8'h00, 0, 0, 1);
    chk("cnt_cleared", {30'b0, bubble_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0, 0);
      chk("cnt_sat", {30'b0, bubble_cnt}, (i < 3) ? i + 1 : 3);
    end
    step(0, 8'h00, 1, 0, 1);
    chk("cnt_clr_wins", {30'b0, bubble_cnt}, 32'd0);

    // Reset while full
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hB1, 0, 0, 0);
    step(1, 8'hB2, 0, 0, 0);
    lit("pre_rst_full", 1, 8'hB1, 0, 2);
    rst = 1'b1;
    step(1, 8'hB3, 1, 0, 1);
    rst = 1'b0;
    lit("mid_rst", 0, 8'h00, 1, 0);
    chk("mid_rst_bubble_cnt", {30'b0, bubble_cnt}, 32'd0);
    step(1, 8'hC1, 0, 0, 0);
    lit("post_rst_accept", 1, 8'hC1, 1, 1);
    step(0, 8'h00, 1, 0, 0);
    lit("post_rst_drain", 0, 8'h00, 1, 0);

    // Random valid/ready soak with in-order scoreboard
    nxt    = 8'h00;
    sb_exp = 8'h00;
    n_acc  = 0;
    sb_on  = 1;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), nxt, 1'($urandom_range(0, 1)), 0, 0);
      if (m_acc) nxt = nxt + 8'h01;
      if ((i % 500) == 0) begin
        out_ready = ~out_ready;
        #1;
        chk("comb_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
        out_ready = ~out_ready;
        #1;
      end
    end
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    sb_on = 0;
    chk("lossless", n_deliv, n_acc);
    lit("soak_end", 0, 8'h00, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
